// File: rtl/multi_port_fifo.sv
// Circular FIFO with N_ENQ enqueue and N_DEQ dequeue lanes per cycle,
// valid/ready handshakes, synchronous flush and full-state preload.
module multi_port_fifo #(
  parameter int unsigned N_ENTRIES   = 8,
  parameter int unsigned ENTRY_WIDTH = 32,
  parameter int unsigned N_ENQ       = 2,
  parameter int unsigned N_DEQ       = 2,
  localparam int unsigned PTR_WIDTH  = $clog2(N_ENTRIES),
  localparam int unsigned CTR_WIDTH  = PTR_WIDTH + 1
) (
  input  logic                               clk,
  input  logic                               rst_aH,
  input  logic [N_ENQ-1:0]                   enq_valid,
  input  logic [N_ENQ*ENTRY_WIDTH-1:0]       enq_data,
  output logic [N_ENQ-1:0]                   enq_ready,
  input  logic [N_DEQ-1:0]                   deq_ready,
  output logic [N_DEQ-1:0]                   deq_valid,
  output logic [N_DEQ*ENTRY_WIDTH-1:0]       deq_data,
  output logic [CTR_WIDTH-1:0]               count,
  input  logic                               flush,
  input  logic                               init,
  input  logic [N_ENTRIES*ENTRY_WIDTH-1:0]   init_entry_reg_state,
  input  logic [CTR_WIDTH-1:0]               init_enq_ptr_state,
  input  logic [CTR_WIDTH-1:0]               init_deq_ptr_state
);

  logic [ENTRY_WIDTH-1:0] entry_q [N_ENTRIES];
  logic [ENTRY_WIDTH-1:0] entry_d [N_ENTRIES];
  logic [CTR_WIDTH-1:0]   enq_ptr_q, enq_ptr_d;
  logic [CTR_WIDTH-1:0]   deq_ptr_q, deq_ptr_d;
  logic [CTR_WIDTH-1:0]   n_enq, n_deq;
  logic                   enq_go, deq_go;

  // Extra pointer bit makes the modular difference distinguish full from empty.
  assign count = enq_ptr_q - deq_ptr_q;

  // Handshake outputs derive only from registered state.
  always_comb begin : outputs
    enq_ready = '0;
    deq_valid = '0;
    deq_data  = '0;
    for (int unsigned i = 0; i < N_ENQ; i++) begin
      enq_ready[i] = (CTR_WIDTH'(N_ENTRIES) - count) > CTR_WIDTH'(i);
    end
    for (int unsigned i = 0; i < N_DEQ; i++) begin
      deq_valid[i] = count > CTR_WIDTH'(i);
      deq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] =
        entry_q[PTR_WIDTH'(deq_ptr_q + CTR_WIDTH'(i))];
    end
  end

  always_comb begin : next_state
    entry_d   = entry_q;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    n_enq     = '0;
    n_deq     = '0;
    enq_go    = 1'b1;
    deq_go    = 1'b1;

    // Acceptance stops at the first lane that does not handshake.
    for (int unsigned i = 0; i < N_ENQ; i++) begin
      if (enq_go && enq_valid[i] && enq_ready[i]) n_enq = n_enq + CTR_WIDTH'(1);
      else                                        enq_go = 1'b0;
    end
    for (int unsigned i = 0; i < N_DEQ; i++) begin
      if (deq_go && deq_valid[i] && deq_ready[i]) n_deq = n_deq + CTR_WIDTH'(1);
      else                                        deq_go = 1'b0;
    end

    if (init) begin
      for (int unsigned e = 0; e < N_ENTRIES; e++) begin
        entry_d[e] = init_entry_reg_state[e*ENTRY_WIDTH +: ENTRY_WIDTH];
      end
      enq_ptr_d = init_enq_ptr_state;
      deq_ptr_d = init_deq_ptr_state;
    end else if (flush) begin
      enq_ptr_d = '0;
      deq_ptr_d = '0;
    end else begin
      for (int unsigned i = 0; i < N_ENQ; i++) begin
        if (CTR_WIDTH'(i) < n_enq) begin
          entry_d[PTR_WIDTH'(enq_ptr_q + CTR_WIDTH'(i))] =
            enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
      end
      enq_ptr_d = enq_ptr_q + n_enq;
      deq_ptr_d = deq_ptr_q + n_deq;
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin : ptr_regs
    if (rst_aH) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin : storage
    entry_q <= entry_d;
  end

endmodule

// File: doc/multi_port_fifo.md
Name: multi_port_fifo

Overview:
- Parametrised circular FIFO with N_ENQ enqueue lanes and N_DEQ dequeue lanes per cycle, all valid/ready handshakes.
- Successor to the single-port fifo; adds multi-lane enq/deq, synchronous flush, a full-width occupancy count, and the existing state-preload (init) capability.
- Sits between superscalar pipeline stages, e.g. fetch-to-decode instruction buffer and dispatch queues.

Parameters:
- N_ENTRIES, 8: depth. Must be a power of 2 and >= max(N_ENQ, N_DEQ).
- ENTRY_WIDTH, 32: bits per entry.
- N_ENQ, 2: enqueue lanes.
- N_DEQ, 2: dequeue lanes.
- PTR_WIDTH (local), $clog2(N_ENTRIES): storage index width.
- CTR_WIDTH (local), PTR_WIDTH+1: pointer/count width; the extra bit disambiguates full from empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_aH  in  1  reset, asynchronous, active-high.
- enq_valid  in  N_ENQ  per-lane enqueue request.
- enq_data  in  N_ENQ x ENTRY_WIDTH  lane i payload.
- enq_ready  out  N_ENQ  lane i may be accepted this cycle.
- deq_ready  in  N_DEQ  per-lane consumer acceptance.
- deq_valid  out  N_DEQ  lane i holds a valid entry.
- deq_data  out  N_DEQ x ENTRY_WIDTH  lane i = entry at deq_ptr+i (mod N_ENTRIES).
- count  out  CTR_WIDTH  occupancy, 0..N_ENTRIES.
- flush  in  1  synchronous empty.
- init  in  1  synchronous state preload.
- init_entry_reg_state  in  N_ENTRIES x ENTRY_WIDTH  preload storage.
- init_enq_ptr_state  in  CTR_WIDTH  preload enqueue pointer.
- init_deq_ptr_state  in  CTR_WIDTH  preload dequeue pointer.

Behaviour:
- State: entry array, enq_ptr and deq_ptr (CTR_WIDTH wrapping counters). Storage index = ptr[PTR_WIDTH-1:0].
- count = enq_ptr - deq_ptr, computed modulo 2^CTR_WIDTH. Full when count == N_ENTRIES; empty when count == 0.
- Reset (async, active-high): enq_ptr = deq_ptr = 0. This forces count = 0, deq_valid = 0 and enq_ready = all ones. Entry contents are don't-care.
- Reset asserted mid-operation clears state immediately, with no clock edge required. In-flight handshakes that cycle are discarded.
- enq_ready[i] = (N_ENTRIES - count) > i. It uses registered count only; same-cycle dequeues do not free space.
- deq_valid[i] = count > i. deq_data is combinational from storage, with zero-cycle latency.
- Lane prefix rule, enqueue: lanes are accepted in order. n_enq = number of leading lanes i with enq_valid[i] & enq_ready[i]. The first lane that fails stops acceptance; later lanes are ignored even if valid.
- Lane prefix rule, dequeue: n_deq is defined the same way from deq_valid & deq_ready.
- Normal edge: lane i of the accepted n_enq writes entry[(enq_ptr+i) mod N_ENTRIES]. Then enq_ptr += n_enq and deq_ptr += n_deq.
- Simultaneous enq and deq: legal in the same cycle; count_next = count + n_enq - n_deq.
- Empty FIFO: an enqueued entry is visible on deq_data[0] in the next cycle. There is no bypass.
- Wrap-around: pointers wrap modulo 2^CTR_WIDTH and indices modulo N_ENTRIES. Multi-lane writes and reads may straddle the end of the array.
- Synchronous priority, highest first: init > flush > normal operation.
- init=1: entries <= init_entry_reg_state, enq_ptr <= init_enq_ptr_state, deq_ptr <= init_deq_ptr_state. All handshakes that cycle are ignored.
- Illegal init: a preload whose pointer difference exceeds N_ENTRIES is illegal and behaviour is undefined.
- flush=1: enq_ptr <= 0, deq_ptr <= 0. Storage is unchanged; handshakes are ignored.
- Outputs are pure functions of registered state. No output depends combinationally on enq_valid or deq_ready.

Test Plan:
- Preload: init=1 with entries 0xDEADBEE0+i, enq_ptr=4'b1001, deq_ptr=4'b0110, one edge -> count=3; deq_valid=2'b11; deq_data[0]=0xDEADBEE6, deq_data[1]=0xDEADBEE7; enq_ready=2'b11.
- Dual enqueue to full: after reset, enq_valid=2'b11 for 4 cycles with data 1..8 -> count=8; enq_ready=2'b00. Then dequeue 2 per cycle -> outputs 1..8 in order; count ends at 0 and deq_valid=0.
- Near-full partial accept: count=7, enq_valid=2'b11 -> enq_ready=2'b01; only lane 0 is written; count=8. Prefix break: enq_valid=2'b10 at count=0 -> nothing accepted; count stays 0.
- Simultaneous with wrap: enq_ptr=7, deq_ptr=5 preloaded. Enq 2 and deq 2 in one cycle -> count stays 2; writes land at indices 7 and 0; deq_data[0] shows entry 7 next cycle.
- Flush vs init: flush=1 with count=5 -> count=0 next cycle. flush=1 and init=1 together -> init values win.
- Async reset: assert rst_aH between edges with count=4 -> count=0 and deq_valid=0 immediately, before the next clock edge. Deassert -> normal operation resumes.
